uart_tx_buffer: RTL and testbench
=================================

UART_TX_BUFFER -- requirements
Module: uart_tx_buffer

Interface
REQ-001 Parameter: DBITS, default 3, UART data word width in bits.
REQ-002 Parameter: DEPTH, default 4, FIFO entries; power of two, at least 2.
REQ-003 clk  input  1  single clock for all logic.
REQ-004 rst  input  1  reset; asynchronous, active-low.
REQ-005 wr_en  input  1  CPU write strobe, one word per cycle.
REQ-006 wr_data  input  DBITS  CPU data word.
REQ-007 full  output  1  FIFO holds DEPTH words.
REQ-008 empty  output  1  FIFO holds 0 words.
REQ-009 count  output  $clog2(DEPTH)+1  number of words currently held.
REQ-010 overflow  output  1  sticky flag: a write was dropped.
REQ-011 tx_start  output  1  one-cycle start pulse to the UART transmitter.
REQ-012 tx_data  output  DBITS  word for the transmitter; feeds its din.
REQ-013 tx_done  input  1  one-cycle completion pulse from the transmitter.

Function
REQ-014 The block SHALL buffer CPU words in a circular FIFO and hand them one at a time to the transmitter.
REQ-015 A write SHALL be accepted when wr_en=1 and full=0 (registered value).
- The word is stored at the write pointer.
- The write pointer increments, modulo DEPTH.
REQ-016 A write with wr_en=1 and full=1 SHALL be dropped, and overflow SHALL be set to 1.
- This holds even if a pop occurs in the same cycle.
REQ-017 overflow SHALL stay 1 until reset.
REQ-018 FSM states: IDLE, LAUNCH, BUSY.
REQ-019 IDLE -> LAUNCH when empty=0.
- On that transition, the head word is registered into tx_data.
- The read pointer increments, modulo DEPTH.
REQ-020 In LAUNCH, tx_start SHALL be 1 for exactly one cycle, then the FSM goes to BUSY.
REQ-021 BUSY -> IDLE on tx_done=1. In all other cycles the FSM remains in BUSY.
REQ-022 tx_done SHALL be ignored in IDLE and LAUNCH.
REQ-023 tx_data SHALL stay stable from LAUNCH until the next IDLE->LAUNCH transition.
REQ-024 Latency: a write accepted at cycle N into an empty FIFO with the FSM in IDLE SHALL produce tx_start=1 at cycle N+2.
REQ-025 Back-to-back words:
- tx_done at cycle M with empty=0 gives IDLE at M+1, LAUNCH at M+2, and tx_start=1 at M+2.
REQ-026 Simultaneous accepted write and pop SHALL leave count unchanged.
REQ-027 count, full and empty SHALL be registered and consistent with the pointers every cycle.
- Pointers are $clog2(DEPTH)+1 bits, with a wrap bit.
- full = MSBs differ and LSBs are equal.
- empty = pointers are equal.
REQ-028 tx_start SHALL never assert while the FSM is in BUSY.

Reset
REQ-029 On rst=0, regardless of clk:
- FSM goes to IDLE.
- Pointers = 0, count = 0.
- empty = 1, full = 0, overflow = 0.
- tx_start = 0, tx_data = 0.
REQ-030 Reset during BUSY or LAUNCH SHALL abort the transfer.
- Buffered words are discarded.
- No tx_start is issued after reset release until a new write is made.
REQ-031 FIFO storage contents need not be reset.

Structure
REQ-032 A shared package uart_pkg SHALL hold:
- DBITS default.
- The FSM state enum type (IDLE, LAUNCH, BUSY).
REQ-033 FIFO storage and pointers SHALL be a sub-module uart_sync_fifo.
- Ports: clk, rst, push, pop, din, dout, full, empty, count.
- uart_tx_buffer SHALL contain the FSM and overflow logic.

Verification
REQ-034 Single word: reset, then write 3'b101 at cycle 10.
- Required: tx_start=1 at cycle 12 only, with tx_data=3'b101.
- Required: after tx_done, FSM is IDLE and empty=1.
REQ-035 Ordering: write 3'b001, 3'b010, 3'b011, 3'b100 back-to-back, with tx_done 20 cycles after each tx_start.
- Required: four tx_start pulses, with tx_data 1, 2, 3, 4 in order.
- Required: full=1 after the 4th write.
REQ-036 Overflow: with DEPTH=4 and the FSM held in BUSY (no tx_done), write 5 words.
- Required: count reaches 4 and stays 4.
- Required: full=1 and overflow=1.
- Required: the 5th word is never transmitted.
REQ-037 Write and pop together: with count=4, write in the same cycle as the IDLE->LAUNCH pop.
- Required: the write is dropped, overflow=1, count=3.
- With count=2, the same action leaves count=2.
REQ-038 Stray done and reset: tx_done pulse in IDLE.
- Required: no state change.
REQ-039 Assert rst=0 mid-BUSY with 3 words queued.
- Required: immediate empty=1, count=0, tx_start=0.
- Required: no tx_start ever follows reset release until a new write.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART transmit buffer.
package uart_pkg;

  localparam int DBITS_DEFAULT = 3;
  localparam int DEPTH_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    BUSY   = 2'd2
  } tx_state_e;

endpackage

// File: rtl/uart_tx_buffer_if.sv
// CPU write side and transmitter handshake of the UART transmit buffer.
interface uart_tx_buffer_if
  import uart_pkg::*;
#(
  parameter int DBITS = DBITS_DEFAULT,
  parameter int DEPTH = DEPTH_DEFAULT
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic             wr_en;
  logic [DBITS-1:0] wr_data;
  logic             full;
  logic             empty;
  logic [CW-1:0]    count;
  logic             overflow;
  logic             tx_start;
  logic [DBITS-1:0] tx_data;
  logic             tx_done;

  modport slave (
    input  wr_en, wr_data, tx_done,
    output full, empty, count, overflow, tx_start, tx_data
  );

  modport master (
    output wr_en, wr_data, tx_done,
    input  full, empty, count, overflow, tx_start, tx_data
  );

endinterface

// File: rtl/uart_sync_fifo.sv
// Circular FIFO with wrap-bit pointers; flags and count are registered.
module uart_sync_fifo
  import uart_pkg::*;
#(
  parameter int DBITS = DBITS_DEFAULT,
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [DBITS-1:0]         din,
  output logic [DBITS-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [DBITS-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr, wr_nxt, rd_nxt;
  logic             push_ok, pop_ok;

  // Flags gate on their registered values, so a push while full is dropped
  // even when a pop frees a slot in the same cycle.
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign wr_nxt  = push_ok ? wr_ptr + PW'(1) : wr_ptr;
  assign rd_nxt  = pop_ok  ? rd_ptr + PW'(1) : rd_ptr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      wr_ptr <= wr_nxt;
      rd_ptr <= rd_nxt;
      count  <= wr_nxt - rd_nxt;
      full   <= (wr_nxt[AW] != rd_nxt[AW]) && (wr_nxt[AW-1:0] == rd_nxt[AW-1:0]);
      empty  <= (wr_nxt == rd_nxt);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= din;
  end

  assign dout = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/uart_tx_buffer.sv
// Buffers CPU words and launches them one at a time into a UART transmitter.
module uart_tx_buffer
  import uart_pkg::*;
#(
  parameter int DBITS = DBITS_DEFAULT,
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input logic             clk,
  input logic             rst,
  uart_tx_buffer_if.slave bus
);

  tx_state_e        state_q;
  logic [DBITS-1:0] tx_data_q;
  logic [DBITS-1:0] fifo_dout;
  logic             tx_start_q;
  logic             overflow_q;
  logic             fifo_pop;

  assign fifo_pop = (state_q == IDLE) && !bus.empty;

  uart_sync_fifo #(
    .DBITS(DBITS),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (bus.wr_en),
    .pop  (fifo_pop),
    .din  (bus.wr_data),
    .dout (fifo_dout),
    .full (bus.full),
    .empty(bus.empty),
    .count(bus.count)
  );

  // tx_start is a registered pulse raised on the pop that enters LAUNCH.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      tx_start_q <= 1'b0;
      if (bus.wr_en && bus.full) overflow_q <= 1'b1;
      case (state_q)
        IDLE: begin
          if (!bus.empty) begin
            state_q    <= LAUNCH;
            tx_start_q <= 1'b1;
            tx_data_q  <= fifo_dout;
          end
        end
        LAUNCH: state_q <= BUSY;
        BUSY: begin
          if (bus.tx_done) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.tx_start = tx_start_q;
  assign bus.tx_data  = tx_data_q;
  assign bus.overflow = overflow_q;

endmodule

// File: tb/tb_uart_tx_buffer.sv
// Scoreboard bench for uart_tx_buffer: writes queue expected words, a monitor checks each launch.
module tb_uart_tx_buffer;
  import uart_pkg::*;

  localparam int DBITS = 3;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic done_auto = 1'b0;
  logic done_man  = 1'b0;
  bit   auto_en   = 1'b0;

  int checks = 0;
  int errors = 0;

  logic [DBITS-1:0] exp_q[$];
  logic [DBITS-1:0] last_data = '0;

  uart_tx_buffer_if #(.DBITS(DBITS), .DEPTH(DEPTH)) bus ();

  assign bus.tx_done = done_auto | done_man;

  uart_tx_buffer #(.DBITS(DBITS), .DEPTH(DEPTH)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every launch must match the head of the scoreboard queue.
  initial begin
    logic [DBITS-1:0] e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        last_data = '0;
      end else if (bus.tx_start) begin
        chk("start_only_in_launch", int'(dut.state_q), int'(LAUNCH));
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_tx_start: got tx_data %0d expected no launch", bus.tx_data);
        end else begin
          e = exp_q.pop_front();
          chk("tx_data_order", int'(bus.tx_data), int'(e));
        end
        last_data = bus.tx_data;
      end else begin
        chk("tx_data_stable", int'(bus.tx_data), int'(last_data));
      end
    end
  end

  // Transmitter model: tx_done 20 cycles after each tx_start when enabled.
  initial begin
    forever begin
      @(negedge clk);
      if (auto_en && rst && bus.tx_start) begin
        repeat (20) @(negedge clk);
        done_auto = 1'b1;
        @(negedge clk);
        done_auto = 1'b0;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic write_word(input logic [DBITS-1:0] d, input bit accept);
    bus.wr_en   = 1'b1;
    bus.wr_data = d;
    if (accept) exp_q.push_back(d);
    @(negedge clk);
    bus.wr_en = 1'b0;
  endtask

  task automatic pulse_done();
    done_man = 1'b1;
    @(negedge clk);
    done_man = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_empty"},    int'(bus.empty), 1);
    chk({tag, "_full"},     int'(bus.full), 0);
    chk({tag, "_count"},    int'(bus.count), 0);
    chk({tag, "_overflow"}, int'(bus.overflow), 0);
    chk({tag, "_tx_start"}, int'(bus.tx_start), 0);
    chk({tag, "_tx_data"},  int'(bus.tx_data), 0);
    chk({tag, "_state"},    int'(dut.state_q), int'(IDLE));
  endtask

  task automatic do_reset(input string tag);
    @(posedge clk);
    #2 rst = 1'b0;
    exp_q.delete();
    #1 check_reset_vals(tag);
    idle(2);
    rst = 1'b1;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 1000; i++) begin
      if (exp_q.size() == 0 && dut.state_q == IDLE && bus.empty) break;
      @(negedge clk);
    end
    chk({tag, "_queue_left"}, exp_q.size(), 0);
    chk({tag, "_state_idle"}, int'(dut.state_q), int'(IDLE));
    chk({tag, "_empty"},      int'(bus.empty), 1);
  endtask

  initial begin
    bus.wr_en   = 1'b0;
    bus.wr_data = '0;
    idle(2);
    check_reset_vals("por");
    rst = 1'b1;

    // Single word: launch exactly two cycles after the accepting edge.
    idle(9);
    write_word(3'b101, 1'b1);
    chk("t1_start_n1", int'(bus.tx_start), 0);
    idle(1);
    chk("t1_start_n2", int'(bus.tx_start), 1);
    chk("t1_tx_data", int'(bus.tx_data), 5);
    idle(1);
    chk("t1_start_n3", int'(bus.tx_start), 0);
    chk("t1_busy", int'(dut.state_q), int'(BUSY));
    idle(3);
    pulse_done();
    chk("t1_idle_after_done", int'(dut.state_q), int'(IDLE));
    chk("t1_empty_after_done", int'(bus.empty), 1);

    // Ordering: lead word keeps the FSM busy so four writes fill the FIFO.
    auto_en = 1'b1;
    write_word(3'b111, 1'b1);
    idle(3);
    write_word(3'b001, 1'b1);
    write_word(3'b010, 1'b1);
    write_word(3'b011, 1'b1);
    write_word(3'b100, 1'b1);
    chk("t2_full", int'(bus.full), 1);
    chk("t2_count", int'(bus.count), 4);
    drain("t2");
    chk("t2_no_overflow", int'(bus.overflow), 0);

    // Overflow with the FSM held in BUSY; 5th word dropped.
    auto_en = 1'b0;
    write_word(3'b110, 1'b1);
    idle(3);
    write_word(3'b011, 1'b1);
    write_word(3'b101, 1'b1);
    write_word(3'b001, 1'b1);
    write_word(3'b010, 1'b1);
    write_word(3'b111, 1'b0);
    chk("t3_count", int'(bus.count), 4);
    chk("t3_full", int'(bus.full), 1);
    chk("t3_overflow", int'(bus.overflow), 1);
    idle(5);
    chk("t3_count_hold", int'(bus.count), 4);
    auto_en = 1'b1;
    pulse_done();
    drain("t3");
    chk("t3_overflow_sticky", int'(bus.overflow), 1);

    // Write in the same cycle as the pop.
    do_reset("rst1");
    auto_en = 1'b0;
    write_word(3'b100, 1'b1);
    idle(3);
    write_word(3'b001, 1'b1);
    write_word(3'b010, 1'b1);
    write_word(3'b011, 1'b1);
    write_word(3'b101, 1'b1);
    chk("t4_count4", int'(bus.count), 4);
    done_man = 1'b1;
    idle(1);
    done_man    = 1'b0;
    bus.wr_en   = 1'b1;
    bus.wr_data = 3'b110;
    idle(1);
    bus.wr_en = 1'b0;
    chk("t4_full_drop_count", int'(bus.count), 3);
    chk("t4_full_drop_overflow", int'(bus.overflow), 1);
    chk("t4_full_drop_full", int'(bus.full), 0);
    idle(2);
    pulse_done();
    idle(3);
    chk("t4_count2", int'(bus.count), 2);
    done_man = 1'b1;
    idle(1);
    done_man    = 1'b0;
    bus.wr_en   = 1'b1;
    bus.wr_data = 3'b111;
    exp_q.push_back(3'b111);
    idle(1);
    bus.wr_en = 1'b0;
    chk("t4_wr_pop_count", int'(bus.count), 2);
    chk("t4_wr_pop_full", int'(bus.full), 0);
    idle(2);
    auto_en = 1'b1;
    pulse_done();
    drain("t4");

    // Stray tx_done in IDLE.
    pulse_done();
    chk("t5_state", int'(dut.state_q), int'(IDLE));
    chk("t5_empty", int'(bus.empty), 1);
    idle(3);
    chk("t5_state_later", int'(dut.state_q), int'(IDLE));
    chk("t5_tx_start", int'(bus.tx_start), 0);

    // Reset in BUSY with three words queued.
    auto_en = 1'b0;
    write_word(3'b010, 1'b1);
    idle(3);
    write_word(3'b011, 1'b1);
    write_word(3'b100, 1'b1);
    write_word(3'b101, 1'b1);
    chk("t6_count3", int'(bus.count), 3);
    chk("t6_busy", int'(dut.state_q), int'(BUSY));
    do_reset("rst2");
    idle(30);
    chk("t6_count_after", int'(bus.count), 0);
    chk("t6_empty_after", int'(bus.empty), 1);
    chk("t6_state_after", int'(dut.state_q), int'(IDLE));
    auto_en = 1'b1;
    write_word(3'b110, 1'b1);
    drain("t6");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
